info_scanner: RTL

Parametrised debug-view scanner for the FPGA controller. It keeps a cursor (source, index) over the processor's observable state: instruction memory, register file, HI/LO and data memory. It reads the word under the cursor through a synchronous read port and refreshes it continuously, so live values stay current. The cursor moves by manual step, direct jump or timed auto-scroll, and the registered result feeds the seven-segment/LCD formatter.

---
 rtl/info_scanner_pkg.sv | 28 ++
 rtl/info_scanner_tick.sv | 26 ++
 rtl/info_scanner.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/info_scanner_pkg.sv
// Shared types and source geometry for the debug-view scanner.
// Source encoding, per-source depths and the read FSM states live here.
package info_scanner_pkg;

  typedef enum logic [1:0] {
    SRC_INSTRUCTION = 2'd0,
    SRC_REGISTER    = 2'd1,
    SRC_HILO        = 2'd2,
    SRC_MEMORY      = 2'd3
  } source_e;

  localparam int NUM_KNOWN_SOURCES = 4;
  localparam int SOURCE_DEPTH [NUM_KNOWN_SOURCES] = '{256, 32, 2, 1024};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE
  } readState_e;

  // Unknown sources behave as a single-word source so the cursor stays sane.
  function automatic int sourceDepth(input int src);
    if (src >= 0 && src < NUM_KNOWN_SOURCES) return SOURCE_DEPTH[src];
    return 1;
  endfunction

endpackage

// File: rtl/info_scanner_tick.sv
// Auto-scroll period generator: emits a one-cycle tick every TICK_DIV cycles.
// Counting restarts from zero whenever it is disabled or cleared.
module tick_divider #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear || !enable) r_count <= '0;
    else if (r_count == LAST)      r_count <= '0;
    else                           r_count <= r_count + CNT_W'(1);
  end

  assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/info_scanner.sv
// Debug-view scanner: keeps a (source, index) cursor and continuously refreshes
// the word under it through a fixed-latency synchronous read port.
module info_scanner
  import info_scanner_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 10,
  parameter int NUM_SOURCES  = 4,
  parameter int READ_LATENCY = 1,
  parameter int TICK_DIV     = 25_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [$clog2(NUM_SOURCES)-1:0] select_in,
  input  logic                           step_up,
  input  logic                           step_down,
  input  logic                           jump_valid,
  input  logic [INDEX_WIDTH-1:0]         jump_index,
  input  logic                           auto_enable,
  output logic                           rd_en,
  output logic [$clog2(NUM_SOURCES)-1:0] rd_source,
  output logic [INDEX_WIDTH-1:0]         rd_index,
  input  logic [WORD_WIDTH-1:0]          rd_data,
  output logic [WORD_WIDTH-1:0]          word,
  output logic [$clog2(NUM_SOURCES)-1:0] word_source,
  output logic [INDEX_WIDTH-1:0]         word_index,
  output logic                           word_valid
);

  localparam int SEL_W  = $clog2(NUM_SOURCES);
  localparam int WCNT_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

  logic [SEL_W-1:0]       r_curSource, w_nextSource, r_issSource, r_wordSource;
  logic [INDEX_WIDTH-1:0] r_curIndex, w_nextIndex, r_issIndex, r_wordIndex;
  logic [INDEX_WIDTH-1:0] w_lastIndex, w_indexUp, w_indexDown;
  logic [WORD_WIDTH-1:0]  r_word;
  logic [WCNT_W-1:0]      r_waitCnt;
  logic                   r_wordValid;
  logic                   w_selChange, w_manual, w_tick, w_curChange, w_load;
  readState_e             r_state, w_nextState;

  assign w_lastIndex = INDEX_WIDTH'(sourceDepth(int'(r_curSource)) - 1);
  assign w_indexUp   = (r_curIndex == w_lastIndex) ? '0 : r_curIndex + INDEX_WIDTH'(1);
  assign w_indexDown = (r_curIndex == '0) ? w_lastIndex : r_curIndex - INDEX_WIDTH'(1);
  assign w_selChange = (select_in != r_curSource);
  assign w_manual    = w_selChange || jump_valid || (step_up ^ step_down);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (auto_enable),
    .clear  (w_manual),
    .tick   (w_tick)
  );

  always_comb begin
    w_nextSource = r_curSource;
    w_nextIndex  = r_curIndex;
    if (w_selChange) begin
      w_nextSource = select_in;
      w_nextIndex  = '0;
    end else if (jump_valid) begin
      w_nextIndex = (jump_index > w_lastIndex) ? w_lastIndex : jump_index;
    end else if (step_up && !step_down) begin
      w_nextIndex = w_indexUp;
    end else if (step_down && !step_up) begin
      w_nextIndex = w_indexDown;
    end else if (!step_up && !step_down && w_tick) begin
      w_nextIndex = w_indexUp;
    end
  end

  assign w_curChange = (w_nextSource != r_curSource) || (w_nextIndex != r_curIndex);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_curSource <= '0;
      r_curIndex  <= '0;
    end else begin
      r_curSource <= w_nextSource;
      r_curIndex  <= w_nextIndex;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // A cursor move during WAIT/CAPTURE abandons the read and reissues at once.
  always_comb begin
    w_nextState = r_state;
    rd_en       = 1'b0;
    case (r_state)
      ST_IDLE:    w_nextState = ST_ISSUE;
      ST_ISSUE: begin
        rd_en       = 1'b1;
        w_nextState = (READ_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        if (w_curChange)                 w_nextState = ST_ISSUE;
        else if (r_waitCnt == WAIT_LAST) w_nextState = ST_CAPTURE;
      end
      ST_CAPTURE: w_nextState = ST_ISSUE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  assign w_load = (r_state == ST_CAPTURE) && !w_curChange;

  // The issued address is latched on entry to ISSUE, so it equals the cursor there.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_waitCnt    <= '0;
      r_issSource  <= '0;
      r_issIndex   <= '0;
      r_word       <= '0;
      r_wordSource <= '0;
      r_wordIndex  <= '0;
      r_wordValid  <= 1'b0;
    end else begin
      if (r_state == ST_ISSUE)     r_waitCnt <= '0;
      else if (r_state == ST_WAIT) r_waitCnt <= r_waitCnt + WCNT_W'(1);
      if (w_nextState == ST_ISSUE) begin
        r_issSource <= w_nextSource;
        r_issIndex  <= w_nextIndex;
      end
      if (w_load) begin
        r_word       <= rd_data;
        r_wordSource <= r_issSource;
        r_wordIndex  <= r_issIndex;
      end
      if (w_curChange)
        r_wordValid <= 1'b0;
      else if (w_load && r_issSource == r_curSource && r_issIndex == r_curIndex)
        r_wordValid <= 1'b1;
    end
  end

  assign rd_source   = r_issSource;
  assign rd_index    = r_issIndex;
  assign word        = r_word;
  assign word_source = r_wordSource;
  assign word_index  = r_wordIndex;
  assign word_valid  = r_wordValid;

endmodule
